// File: rtl/axi_stream_merge_channel.sv
// axi_stream_merge_channel
//
// Rejoins a packet that an upstream splitter divided into a head channel
// (first split_len beats, terminated by an inserted tlast) and a tail channel
// (the remaining beats). One head packet is drained from s0. If its length
// matches the latched split length, its tlast is suppressed and exactly one
// tail packet is then drained from s1. The merged beats go through a
// 2-entry register skid buffer, so every m_* output comes from a flop.
//
// Ports
//   clock, rst        : single rising-edge clock, synchronous active-high reset
//   split_len[15:0]   : head length used by the splitter (0 = passthrough)
//   s0_*              : head channel (tdata/tkeep/tuser/tlast/tvalid/tready)
//   s1_*              : tail channel (tdata/tkeep/tuser/tlast/tvalid/tready)
//   m_*               : merged output stream
//   len_err           : 1-cycle pulse when a head packet exceeds split_len
//   pkt_cnt[15:0]     : number of merged packets written, wraps at 0xFFFF
module axi_stream_merge_channel #(
  parameter int DSIZE = 8,
  parameter int KSIZE = DSIZE / 8,
  parameter int USIZE = 1
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [15:0]      split_len,

  input  logic [DSIZE-1:0] s0_tdata,
  input  logic [KSIZE-1:0] s0_tkeep,
  input  logic [USIZE-1:0] s0_tuser,
  input  logic             s0_tlast,
  input  logic             s0_tvalid,
  output logic             s0_tready,

  input  logic [DSIZE-1:0] s1_tdata,
  input  logic [KSIZE-1:0] s1_tkeep,
  input  logic [USIZE-1:0] s1_tuser,
  input  logic             s1_tlast,
  input  logic             s1_tvalid,
  output logic             s1_tready,

  output logic [DSIZE-1:0] m_tdata,
  output logic [KSIZE-1:0] m_tkeep,
  output logic [USIZE-1:0] m_tuser,
  output logic             m_tlast,
  output logic             m_tvalid,
  input  logic             m_tready,

  output logic             len_err,
  output logic [15:0]      pkt_cnt
);

  // Beat layout inside the buffer: {tlast, tuser, tkeep, tdata}
  localparam int BW = DSIZE + KSIZE + USIZE + 1;

  typedef enum logic {HEAD = 1'b0, TAIL = 1'b1} state_t;

  state_t          state, state_n;
  logic [15:0]     hcnt, hcnt_n;
  logic [15:0]     sl_q, sl_n, sl_cur;
  logic [16:0]     hcnt_inc;
  logic            len_err_n;
  logic            pkt_inc;
  logic            wr_en;
  logic            wr_last;
  logic [BW-1:0]   wr_beat;

  // Output register (what m_* shows) and the skid register behind it
  logic            out_vld;
  logic [BW-1:0]   out_beat;
  logic            skid_vld;
  logic [BW-1:0]   skid_beat;

  // Held low through reset so the readies rise only the cycle after rst drops
  logic            active;
  logic            in_ready;
  logic            head_hs;
  logic            tail_hs;
  logic            pop;

  // Readies see only flops: no path from m_tready to s*_tready
  assign in_ready  = active && !skid_vld;
  assign s0_tready = in_ready && (state == HEAD);
  assign s1_tready = in_ready && (state == TAIL);

  assign head_hs = s0_tvalid && s0_tready;
  assign tail_hs = s1_tvalid && s1_tready;
  assign pop     = out_vld && m_tready;

  // split_len is sampled on the first head beat (hcnt still 0) and held
  // for the rest of the packet
  assign sl_cur   = (hcnt == 16'd0) ? split_len : sl_q;
  assign hcnt_inc = {1'b0, hcnt} + 17'd1;

  always_comb begin
    state_n   = state;
    hcnt_n    = hcnt;
    sl_n      = sl_q;
    len_err_n = 1'b0;
    pkt_inc   = 1'b0;
    wr_en     = 1'b0;
    wr_last   = s0_tlast;
    wr_beat   = {s0_tlast, s0_tuser, s0_tkeep, s0_tdata};
    case (state)
      HEAD: begin
        if (head_hs) begin
          wr_en = 1'b1;
          if (hcnt == 16'd0) sl_n = split_len;
          if (s0_tlast) begin
            hcnt_n = 16'd0;
            if ((sl_cur != 16'd0) && (hcnt_inc == {1'b0, sl_cur})) begin
              // Inserted tlast: hide it and wait for the tail
              wr_last = 1'b0;
              state_n = TAIL;
            end else begin
              pkt_inc = 1'b1;
            end
            if ((sl_cur != 16'd0) && (hcnt_inc > {1'b0, sl_cur})) len_err_n = 1'b1;
          end else if (hcnt != 16'hFFFF) begin
            hcnt_n = hcnt_inc[15:0];
          end
        end
        wr_beat = {wr_last, s0_tuser, s0_tkeep, s0_tdata};
      end
      TAIL: begin
        wr_beat = {s1_tlast, s1_tuser, s1_tkeep, s1_tdata};
        if (tail_hs) begin
          wr_en = 1'b1;
          if (s1_tlast) begin
            state_n = HEAD;
            pkt_inc = 1'b1;
          end
        end
      end
      default: state_n = HEAD;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state   <= HEAD;
      hcnt    <= 16'd0;
      sl_q    <= 16'd0;
      len_err <= 1'b0;
      pkt_cnt <= 16'd0;
      active  <= 1'b0;
    end else begin
      state   <= state_n;
      hcnt    <= hcnt_n;
      sl_q    <= sl_n;
      len_err <= len_err_n;
      pkt_cnt <= pkt_cnt + {15'd0, pkt_inc};
      active  <= 1'b1;
    end
  end

  // Skid buffer: a write lands in the output register when it is free or
  // draining, otherwise in the skid register. Writes never arrive while the
  // skid register is occupied because the input readies are low then.
  always_ff @(posedge clock) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_beat <= '0;
      skid_vld <= 1'b0;
    end else if (skid_vld) begin
      if (pop) begin
        out_beat <= skid_beat;
        skid_vld <= 1'b0;
      end
    end else if (wr_en) begin
      if (!out_vld || pop) begin
        out_beat <= wr_beat;
        out_vld  <= 1'b1;
      end else begin
        skid_beat <= wr_beat;
        skid_vld  <= 1'b1;
      end
    end else if (pop) begin
      out_vld <= 1'b0;
    end
  end

  assign m_tvalid = out_vld;
  assign m_tdata  = out_beat[DSIZE-1:0];
  assign m_tkeep  = out_beat[DSIZE +: KSIZE];
  assign m_tuser  = out_beat[DSIZE+KSIZE +: USIZE];
  assign m_tlast  = out_beat[BW-1];

endmodule
